lvds_rx_arbiter: RTL
====================

# lvds_rx_arbiter

Merges the sample streams of the two LVDS receiver channels (ch0 = sub-GHz, ch1 = 2.4 GHz), already in the `i_ddr_clk` domain, onto the single shared RX FIFO write port. Each channel has a 2-entry skid buffer. Service is round-robin. Samples that cannot be buffered are dropped and counted. A channel-select mode register is applied only at a quiescent point, so a mode change never splits a sample pair.

## Interface
- `DW`, 16: sample word width per push.
- `CW`, 16: drop-counter width.
- `i_ddr_clk` in 1: single clock for receivers, arbiter and FIFO write side.
- `i_rst_b` in 1: reset, asynchronous, active-low.
- `i_mode` in 2: channel select. 00 = off, 01 = ch0 only, 10 = ch1 only, 11 = both (round-robin).
- `i_ch0_push`, `i_ch1_push` in 1: one-cycle push strobe from each receiver.
- `i_ch0_data`, `i_ch1_data` in DW: sample word, valid with its push.
- `i_ch0_sync`, `i_ch1_sync` in 1: sync mark accompanying the sample.
- `i_fifo_full` in 1: shared FIFO full flag.
- `o_fifo_push` out 1: write strobe.
- `o_fifo_data` out DW+2: `{sync, ch, data}`.
- `o_mode_active` out 2: currently applied mode.
- `o_mode_pending` out 1: a new mode is waiting to be applied.
- `o_ch0_drops`, `o_ch1_drops` out CW: saturating drop counters.
- `i_clr_drops` in 1: synchronous clear of both counters.

## Operation
- Reset values:
  - `o_fifo_push` = 0, `o_fifo_data` = 0.
  - `o_mode_active` = 00, `o_mode_pending` = 0.
  - Both drop counters 0, buffers empty, round-robin pointer = ch0.
- Mode sequencing FSM, states MODE_RUN and MODE_DRAIN:
  - MODE_RUN → MODE_DRAIN when `i_mode` != `o_mode_active`.
  - In MODE_DRAIN, new pushes are ignored and not counted. Buffers keep draining.
  - MODE_DRAIN → MODE_RUN when both buffers are empty and `i_fifo_full` = 0. On that edge `o_mode_active` <= `i_mode`.
  - `o_mode_pending` = 1 exactly while in MODE_DRAIN.
- Acceptance in MODE_RUN:
  - A push on a channel enabled in `o_mode_active` writes `{sync, data}` into that channel's buffer.
  - A push on a disabled channel is ignored and not counted.
- Buffer overflow:
  - A push to an enabled channel whose buffer holds 2 entries, with no pop in the same cycle, is dropped.
  - The drop increments that channel's counter.
  - A push and a pop in the same cycle on a full buffer is accepted, not dropped.
- Arbitration, evaluated each cycle with `i_fifo_full` = 0:
  - Only one buffer non-empty: that buffer is granted, and the pointer moves to the other channel.
  - Both buffers non-empty: the pointer's channel is granted, and the pointer toggles.
  - The granted buffer pops its head. The next cycle drives `o_fifo_push` = 1 with `o_fifo_data` = `{sync, ch, data}`.
- FIFO full: no grant and no pop. Samples remain buffered. Loss happens only through buffer overflow, which is counted.
- Counters:
  - Saturate at 2^CW − 1.
  - `i_clr_drops` clears both counters.
  - An overflow in the same cycle as `i_clr_drops` leaves the counter at 1 (clear, then count).

## Timing
- Latency: push at cycle N into an empty buffer, uncontended, not full → `o_fifo_push` at cycle N+1.
- Simultaneous ch0/ch1 push with pointer = ch0 → ch0 word at N+1, ch1 word at N+2.
- Throughput: one FIFO write per cycle maximum.
- Each receiver pushes at most 2 words per 16 cycles, so contention alone never causes overflow.
- `o_fifo_push` is a registered single-cycle strobe per word. `o_fifo_data` is held between pushes.
- Asynchronous reset mid-stream empties the buffers immediately. In-flight words are lost and not counted.

## Configuration
- `LVDS_RX_ARB_DROP_CNT_EN`:
  - Defined: drop counters and `i_clr_drops` behave as above.
  - Undefined: counter logic is removed, `o_ch0_drops` and `o_ch1_drops` are tied to 0, and `i_clr_drops` is ignored.
  - All other behaviour is identical.

## Structure
- Shared package holds:
  - Mode constants `MODE_OFF`, `MODE_CH0`, `MODE_CH1`, `MODE_BOTH`.
  - Channel tag constants `CH0` = 0, `CH1` = 1.
  - FSM state encodings `MODE_RUN`, `MODE_DRAIN`.
- One sub-module, `lvds_rx_skid2`, instantiated once per channel:
  - 2-entry buffer with push, pop, empty, full and overflow outputs.
  - Arbitration, mode FSM and counters stay in the top module.

## Test plan
- Mode 01, single ch0 push of 0x1234, sync = 1 → `o_fifo_push` one cycle later with data `{1, 0, 0x1234}`. No ch1 output even if ch1 pushes.
- Mode 11, ch0 0xAAAA and ch1 0x5555 pushed in the same cycle, pointer = ch0 → 0xAAAA (ch = 0) then 0x5555 (ch = 1) on consecutive cycles. A repeat collision gives ch1 first.
- Mode 11, `i_fifo_full` held for 4 cycles while ch0 pushes 4 words → first 2 words emitted after full drops, `o_ch0_drops` = 2.
- Mode 11, while ch1 holds 2 buffered words and FIFO is full, switch to mode 01:
  - `o_mode_pending` = 1.
  - ch0 pushes during the pending period are ignored.
  - After full drops, both words drain and then `o_mode_active` = 01.
- Force 65537 overflows on ch1 → counter holds 0xFFFF. Pulse `i_clr_drops` with a simultaneous overflow → 1.
- Assert `i_rst_b` low mid-transfer → all outputs return to reset values asynchronously. After release, a new push appears at N+1.

Source files
------------

// File: rtl/lvds_rx_arbiter_pkg.sv
// Shared constants for the LVDS RX arbiter: mode encodings, channel tags and
// the mode-sequencing state type.
package lvds_rx_arbiter_pkg;

  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_CH0  = 2'b01;
  localparam logic [1:0] MODE_CH1  = 2'b10;
  localparam logic [1:0] MODE_BOTH = 2'b11;

  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;

  typedef enum logic {
    MODE_RUN   = 1'b0,
    MODE_DRAIN = 1'b1
  } mode_state_e;

  // Bit n of the mode word enables channel n.
  function automatic logic ch_enabled(input logic [1:0] mode, input logic ch);
    return mode[ch];
  endfunction

endpackage

// File: rtl/lvds_rx_arbiter_if.sv
// Receiver push streams and shared RX FIFO write port of the LVDS RX arbiter.
// The arbiter takes the slave modport; receivers and FIFO side take master.
interface lvds_rx_arbiter_if #(
  parameter int DW = 16
);
  logic          i_ch0_push;
  logic [DW-1:0] i_ch0_data;
  logic          i_ch0_sync;
  logic          i_ch1_push;
  logic [DW-1:0] i_ch1_data;
  logic          i_ch1_sync;
  logic          i_fifo_full;
  logic          o_fifo_push;
  logic [DW+1:0] o_fifo_data;

  modport master (
    output i_ch0_push, i_ch0_data, i_ch0_sync,
    output i_ch1_push, i_ch1_data, i_ch1_sync,
    output i_fifo_full,
    input  o_fifo_push, o_fifo_data
  );

  modport slave (
    input  i_ch0_push, i_ch0_data, i_ch0_sync,
    input  i_ch1_push, i_ch1_data, i_ch1_sync,
    input  i_fifo_full,
    output o_fifo_push, o_fifo_data
  );
endinterface

// File: rtl/lvds_rx_skid2.sv
// Two-entry skid buffer for one receiver channel. When empty, the incoming
// word is presented on dout in the same cycle so it can be popped straight through.
module lvds_rx_skid2 #(
  parameter int W = 17
) (
  input  logic         i_ddr_clk,
  input  logic         i_rst_b,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full,
  output logic         overflow
);

  logic [W-1:0] mem_r [2];
  logic [1:0]   cnt_r;
  logic         wr_ptr_r;
  logic         rd_ptr_r;
  logic         store_s;
  logic         take_s;

  // Occupancy flags, overflow detection and head/bypass selection.
  always_comb begin
    empty    = (cnt_r == 2'd0);
    full     = (cnt_r == 2'd2);
    overflow = push && full && !pop;
    store_s  = push && !overflow && !(empty && pop);
    take_s   = pop && !empty;
    if (empty) begin
      dout = din;
    end else begin
      dout = mem_r[rd_ptr_r];
    end
  end

  // Storage, pointers and occupancy count.
  always_ff @(posedge i_ddr_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      mem_r[0] <= {W{1'b0}};
      mem_r[1] <= {W{1'b0}};
      cnt_r    <= 2'd0;
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
    end else begin
      if (store_s) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= ~wr_ptr_r;
      end
      if (take_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({store_s, take_s})
        2'b10:   cnt_r <= cnt_r + 2'd1;
        2'b01:   cnt_r <= cnt_r - 2'd1;
        default: cnt_r <= cnt_r;
      endcase
    end
  end

endmodule

// File: rtl/lvds_rx_arbiter.sv
// Round-robin merge of two LVDS receiver streams onto one RX FIFO write port,
// with drain-then-switch mode changes. LVDS_RX_ARB_DROP_CNT_EN enables drop counters.
module lvds_rx_arbiter
  import lvds_rx_arbiter_pkg::*;
#(
  parameter int DW = 16,
  parameter int CW = 16
) (
  input  logic                 i_ddr_clk,
  input  logic                 i_rst_b,
  input  logic [1:0]           i_mode,
  input  logic                 i_clr_drops,
  lvds_rx_arbiter_if.slave     bus,
  output logic [1:0]           o_mode_active,
  output logic                 o_mode_pending,
  output logic [CW-1:0]        o_ch0_drops,
  output logic [CW-1:0]        o_ch1_drops
);

  mode_state_e   state_r;
  logic [1:0]    mode_active_r;
  logic          mode_pending_r;
  logic          ptr_r;
  logic          push_r;
  logic [DW+1:0] data_r;

  logic          acc0_s, acc1_s;
  logic          req0_s, req1_s;
  logic          grant_s, grant_ch_s;
  logic          pop0_s, pop1_s;
  logic [DW:0]   head0_s, head1_s, head_s;
  logic          empty0_s, empty1_s;
  logic          full0_s, full1_s;
  logic          ovf0_s, ovf1_s;

  // Acceptance gating and round-robin grant, including same-cycle bypass.
  always_comb begin
    acc0_s     = (state_r == MODE_RUN) && bus.i_ch0_push && ch_enabled(mode_active_r, CH0);
    acc1_s     = (state_r == MODE_RUN) && bus.i_ch1_push && ch_enabled(mode_active_r, CH1);
    req0_s     = !empty0_s || acc0_s;
    req1_s     = !empty1_s || acc1_s;
    grant_s    = 1'b0;
    grant_ch_s = ptr_r;
    if (bus.i_fifo_full) begin
      grant_s    = 1'b0;
      grant_ch_s = ptr_r;
    end else if (req0_s && req1_s) begin
      grant_s    = 1'b1;
      grant_ch_s = ptr_r;
    end else if (req0_s) begin
      grant_s    = 1'b1;
      grant_ch_s = CH0;
    end else if (req1_s) begin
      grant_s    = 1'b1;
      grant_ch_s = CH1;
    end else begin
      grant_s    = 1'b0;
      grant_ch_s = ptr_r;
    end
    pop0_s = grant_s && (grant_ch_s == CH0);
    pop1_s = grant_s && (grant_ch_s == CH1);
    if (grant_ch_s == CH1) begin
      head_s = head1_s;
    end else begin
      head_s = head0_s;
    end
  end

  lvds_rx_skid2 #(.W(DW + 1)) u_skid_ch0 (
    .i_ddr_clk (i_ddr_clk),
    .i_rst_b   (i_rst_b),
    .push      (acc0_s),
    .din       ({bus.i_ch0_sync, bus.i_ch0_data}),
    .pop       (pop0_s),
    .dout      (head0_s),
    .empty     (empty0_s),
    .full      (full0_s),
    .overflow  (ovf0_s)
  );

  lvds_rx_skid2 #(.W(DW + 1)) u_skid_ch1 (
    .i_ddr_clk (i_ddr_clk),
    .i_rst_b   (i_rst_b),
    .push      (acc1_s),
    .din       ({bus.i_ch1_sync, bus.i_ch1_data}),
    .pop       (pop1_s),
    .dout      (head1_s),
    .empty     (empty1_s),
    .full      (full1_s),
    .overflow  (ovf1_s)
  );

  // FIFO write strobe, held write data and round-robin pointer.
  always_ff @(posedge i_ddr_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      push_r <= 1'b0;
      data_r <= {(DW + 2){1'b0}};
      ptr_r  <= CH0;
    end else begin
      push_r <= grant_s;
      if (grant_s) begin
        data_r <= {head_s[DW], grant_ch_s, head_s[DW-1:0]};
        ptr_r  <= ~grant_ch_s;
      end
    end
  end

  // Mode sequencing: a new mode is applied only once both buffers have drained.
  always_ff @(posedge i_ddr_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      state_r        <= MODE_RUN;
      mode_active_r  <= MODE_OFF;
      mode_pending_r <= 1'b0;
    end else begin
      case (state_r)
        MODE_RUN: begin
          if (i_mode != mode_active_r) begin
            state_r        <= MODE_DRAIN;
            mode_pending_r <= 1'b1;
          end
        end
        MODE_DRAIN: begin
          if (empty0_s && empty1_s && !bus.i_fifo_full) begin
            state_r        <= MODE_RUN;
            mode_pending_r <= 1'b0;
            mode_active_r  <= i_mode;
          end
        end
        default: begin
          state_r        <= MODE_RUN;
          mode_pending_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_fifo_push = push_r;
  assign bus.o_fifo_data = data_r;
  assign o_mode_active   = mode_active_r;
  assign o_mode_pending  = mode_pending_r;

  logic unused_full_s;
  assign unused_full_s = full0_s ^ full1_s;

`ifdef LVDS_RX_ARB_DROP_CNT_EN
  localparam logic [CW-1:0] DROP_MAX = {CW{1'b1}};
  localparam logic [CW-1:0] DROP_ONE = {{(CW - 1){1'b0}}, 1'b1};

  logic [CW-1:0] drops0_r, drops1_r;

  // Clear takes effect first, so an overflow in the clear cycle leaves a count of one.
  function automatic logic [CW-1:0] drop_next(input logic [CW-1:0] cnt,
                                              input logic clr, input logic ovf);
    if (clr) begin
      return ovf ? DROP_ONE : {CW{1'b0}};
    end else if (ovf && (cnt != DROP_MAX)) begin
      return cnt + DROP_ONE;
    end else begin
      return cnt;
    end
  endfunction

  // Saturating per-channel drop counters.
  always_ff @(posedge i_ddr_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      drops0_r <= {CW{1'b0}};
      drops1_r <= {CW{1'b0}};
    end else begin
      drops0_r <= drop_next(drops0_r, i_clr_drops, ovf0_s);
      drops1_r <= drop_next(drops1_r, i_clr_drops, ovf1_s);
    end
  end

  assign o_ch0_drops = drops0_r;
  assign o_ch1_drops = drops1_r;
`else
  logic unused_drop_s;
  assign unused_drop_s = ^{i_clr_drops, ovf0_s, ovf1_s};
  assign o_ch0_drops   = {CW{1'b0}};
  assign o_ch1_drops   = {CW{1'b0}};
`endif

endmodule
